// File: rtl/circuit2_pkg.sv
// circuit2_pkg: shared types and constants for the circuit2 BIST controller.
//   state_e         controller FSM states
//   VEC_W           width of the {A,B,C} vector index
//   ERR_W           width of the mismatch counter (holds 0..8)
//   CNT_W           width of the settle down-counter
//   CIRCUIT2_TRUTH  golden truth table of D = A | (B & C), bit i <-> {A,B,C} == i
package circuit2_pkg;

  localparam int unsigned VEC_W = 3;
  localparam int unsigned ERR_W = 4;
  localparam int unsigned CNT_W = 4;

  localparam logic [7:0] CIRCUIT2_TRUTH = 8'hF8;

  typedef enum logic [1:0] {
    StIdle,
    StApply,
    StSample,
    StDone
  } state_e;

endpackage

// File: rtl/circuit2_settle_timer.sv
// circuit2_settle_timer: 4-bit loadable down-counter that times the settle window
// of each test vector.
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset
//   load_i   load value_i into the counter (wins over dec_i)
//   value_i  load value
//   dec_i    decrement by one; holds at zero
//   zero_o   counter currently reads zero
module circuit2_settle_timer
  import circuit2_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/circuit2_bist_ctrl.sv
// circuit2_bist_ctrl: self-test sequencer for the external datapath D = A | (B & C).
// On start it steps {A,B,C} through 0..7, holds each vector SETTLE+1 cycles, samples D
// at the end of each window and compares it against EXPECTED.
//   clk, rst         clock (rising edge), synchronous active-high reset
//   start            launch a sweep; only accepted while idle
//   A, B, C          datapath stimulus (000 outside a sweep)
//   D                datapath response
//   busy             sweep in progress
//   done             one-cycle pulse at the end of a sweep
//   pass             last sweep had zero mismatches
//   err_count        mismatches in the last sweep
//   fail_valid       at least one mismatch recorded
//   first_fail       {A,B,C} of the first mismatch
module circuit2_bist_ctrl
  import circuit2_pkg::*;
#(
  parameter int unsigned SETTLE   = 1,
  parameter logic [7:0]  EXPECTED = CIRCUIT2_TRUTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             A,
  output logic             B,
  output logic             C,
  input  logic             D,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [VEC_W-1:0] first_fail
);

  localparam bit               HasSettle  = (SETTLE != 0);
  // Counter reads SETTLE-1 on the first APPLY cycle, so APPLY lasts SETTLE cycles.
  localparam logic [CNT_W-1:0] SettleLoad = HasSettle ? CNT_W'(SETTLE - 1) : '0;
  localparam logic [ERR_W-1:0] ErrMax     = ERR_W'(8);

  state_e           state_d, state_q;
  logic [VEC_W-1:0] vec_d, vec_q;
  logic [ERR_W-1:0] err_d, err_q;
  logic             fv_d, fv_q;
  logic [VEC_W-1:0] ff_d, ff_q;
  logic             pass_d, pass_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;
  logic             tmr_load, tmr_dec, tmr_zero;
  logic [VEC_W-1:0] abc;

  circuit2_settle_timer u_timer (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (tmr_load),
    .value_i (SettleLoad),
    .dec_i   (tmr_dec),
    .zero_o  (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    err_d    = err_q;
    fv_d     = fv_q;
    ff_d     = ff_q;
    pass_d   = pass_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          vec_d    = '0;
          err_d    = '0;
          fv_d     = 1'b0;
          ff_d     = '0;
          pass_d   = 1'b0;
          tmr_load = 1'b1;
          state_d  = HasSettle ? StApply : StSample;
        end
      end
      StApply: begin
        if (tmr_zero) begin
          state_d = StSample;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      StSample: begin
        if (D != EXPECTED[vec_q]) begin
          if (err_q != ErrMax) begin
            err_d = err_q + 1'b1;
          end
          if (!fv_q) begin
            fv_d = 1'b1;
            ff_d = vec_q;
          end
        end
        if (vec_q == VEC_W'(7)) begin
          state_d = StDone;
          // Uses err_d so the final vector's result is included.
          pass_d  = (err_d == '0);
        end else begin
          vec_d    = vec_q + 1'b1;
          tmr_load = 1'b1;
          state_d  = HasSettle ? StApply : StSample;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    busy_d = (state_d == StApply) || (state_d == StSample);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      vec_q   <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ff_q    <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ff_q    <= ff_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    abc = '0;
    if ((state_q == StApply) || (state_q == StSample)) begin
      abc = vec_q;
    end
  end

  assign {A, B, C}  = abc;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_circuit2_bist_ctrl.sv
// Bench for circuit2_bist_ctrl: three instances (SETTLE = 0, 1, 3), each driving its own
// modelled datapath given as an 8-entry truth table. A sweep-level model predicts every
// output from the number of cycles elapsed since the accepted start.
module tb_circuit2_bist_ctrl;

  localparam logic [7:0] Golden = 8'hF8;

  logic       clk = 1'b0;
  logic [2:0] rst_v = 3'b111;
  logic [2:0] start_v = 3'b000;
  logic       a_v [3];
  logic       b_v [3];
  logic       c_v [3];
  logic       d_v [3];
  logic       busy_v [3];
  logic       done_v [3];
  logic       pass_v [3];
  logic       fv_v [3];
  logic [3:0] err_v [3];
  logic [2:0] ff_v [3];
  logic [7:0] tbl [3] = '{8'hF8, 8'hF8, 8'hF8};

  int         tests = 0;
  int         fails = 0;
  bit         cmp_en = 1'b0;

  // Model state: n_m = cycles since busy rose (-1 when idle), snap_m = datapath table
  // captured at start, resv_m = results of a completed sweep are being held.
  int         n_m [3] = '{-1, -1, -1};
  logic [7:0] snap_m [3] = '{8'hF8, 8'hF8, 8'hF8};
  bit         resv_m [3] = '{1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  assign d_v[0] = tbl[0][{a_v[0], b_v[0], c_v[0]}];
  assign d_v[1] = tbl[1][{a_v[1], b_v[1], c_v[1]}];
  assign d_v[2] = tbl[2][{a_v[2], b_v[2], c_v[2]}];

  circuit2_bist_ctrl #(.SETTLE(0)) u_s0 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .A(a_v[0]), .B(b_v[0]), .C(c_v[0]),
    .D(d_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err_v[0]),
    .fail_valid(fv_v[0]), .first_fail(ff_v[0])
  );
  circuit2_bist_ctrl #(.SETTLE(1)) u_s1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .A(a_v[1]), .B(b_v[1]), .C(c_v[1]),
    .D(d_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err_v[1]),
    .fail_valid(fv_v[1]), .first_fail(ff_v[1])
  );
  circuit2_bist_ctrl #(.SETTLE(3)) u_s3 (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .A(a_v[2]), .B(b_v[2]), .C(c_v[2]),
    .D(d_v[2]), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(err_v[2]),
    .fail_valid(fv_v[2]), .first_fail(ff_v[2])
  );

  // Cycles per vector for instance k.
  function automatic int per(input int k);
    case (k)
      0:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  // Packed {busy, done, A, B, C, pass, err_count, fail_valid, first_fail}.
  function automatic logic [13:0] dut_out(input int k);
    return {busy_v[k], done_v[k], a_v[k], b_v[k], c_v[k], pass_v[k], err_v[k], fv_v[k],
            ff_v[k]};
  endfunction

  function automatic logic [13:0] model_out(input int k);
    int         p = per(k);
    int         len = 8 * p;
    int         n = n_m[k];
    int         kv = 0;
    bit         show_pass = 1'b0;
    logic       busy = 1'b0;
    logic       done = 1'b0;
    logic [2:0] abc = 3'd0;
    logic [7:0] mism = snap_m[k] ^ Golden;
    logic [3:0] err = 4'd0;
    logic       fv = 1'b0;
    logic [2:0] first = 3'd0;
    if (n < 0) begin
      kv = resv_m[k] ? 8 : 0;
      show_pass = resv_m[k];
    end else if (n < len) begin
      busy = 1'b1;
      abc  = 3'(n / p);
      kv   = n / p;   // vectors whose sample edge has already passed
    end else begin
      done = 1'b1;
      kv = 8;
      show_pass = 1'b1;
    end
    for (int v = 0; v < 8; v++) begin
      if (v < kv && mism[v]) begin
        if (!fv) begin
          fv = 1'b1;
          first = 3'(v);
        end
        err = err + 4'd1;
      end
    end
    return {busy, done, abc, show_pass && (err == 4'd0), err, fv, first};
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model advance at each active edge, using the inputs held across that edge.
  initial begin
    forever begin
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rst_v[k]) begin
          n_m[k] = -1;
          resv_m[k] = 1'b0;
        end else if (n_m[k] < 0) begin
          if (start_v[k]) begin
            n_m[k] = 0;
            snap_m[k] = tbl[k];
            resv_m[k] = 1'b0;
          end
        end else if (n_m[k] == 8 * per(k)) begin
          n_m[k] = -1;
          resv_m[k] = 1'b1;
        end else begin
          n_m[k] = n_m[k] + 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        for (int k = 0; k < 3; k++) begin
          logic [13:0] got;
          logic [13:0] exp;
          got = dut_out(k);
          exp = model_out(k);
          tests++;
          if (got !== exp) begin
            fails++;
            $display("FAIL model inst%0d: got %b, expected %b (t=%0t)", k, got, exp, $time);
          end
        end
      end
    end
  end

  task automatic pulse_start(input int k);
    @(posedge clk);
    #1 start_v[k] = 1'b1;
    @(posedge clk);
    #1 start_v[k] = 1'b0;
  endtask

  // Returns cycles from busy rising to done, and how many cycles showed {A,B,C} = 101.
  task automatic wait_done(input int k, output int lat, output int n5);
    lat = -1;
    n5 = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ({a_v[k], b_v[k], c_v[k]} == 3'b101) n5++;
      if (done_v[k]) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout inst%0d: got no done, expected done within 100 cycles", k);
    end
  endtask

  int lat;
  int n5;
  int dcnt;

  initial begin
    repeat (3) @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk($sformatf("reset_outputs_inst%0d", k), int'(dut_out(k)), 0);
    @(posedge clk);
    #1 rst_v = 3'b000;

    // Good datapath, SETTLE = 1.
    tbl[1] = 8'hF8;
    pulse_start(1);
    wait_done(1, lat, n5);
    chk("s1_good_latency", lat, 16);
    chk("s1_good_pass", int'(pass_v[1]), 1);
    chk("s1_good_err", int'(err_v[1]), 0);
    chk("s1_good_fv", int'(fv_v[1]), 0);

    // D stuck at 0.
    tbl[1] = 8'h00;
    pulse_start(1);
    wait_done(1, lat, n5);
    chk("stuck0_err", int'(err_v[1]), 5);
    chk("stuck0_fv", int'(fv_v[1]), 1);
    chk("stuck0_first", int'(ff_v[1]), 3);
    chk("stuck0_pass", int'(pass_v[1]), 0);

    // D = A: only vector 011 differs.
    tbl[1] = 8'hF0;
    pulse_start(1);
    wait_done(1, lat, n5);
    chk("d_eq_a_err", int'(err_v[1]), 1);
    chk("d_eq_a_first", int'(ff_v[1]), 3);

    // Restart attempt while busy is ignored; fresh sweep clears old results.
    tbl[1] = 8'hF8;
    pulse_start(1);
    fork
      wait_done(1, lat, n5);
      begin
        repeat (5) @(posedge clk);
        #1 start_v[1] = 1'b1;
        @(posedge clk);
        #1 start_v[1] = 1'b0;
      end
    join
    chk("busy_start_latency", lat, 16);
    chk("busy_start_pass", int'(pass_v[1]), 1);
    chk("busy_start_err", int'(err_v[1]), 0);

    // Reset while vec == 4 (offsets 8..9 for SETTLE = 1).
    tbl[1] = 8'h00;
    pulse_start(1);
    repeat (8) @(posedge clk);
    #1 rst_v[1] = 1'b1;
    @(negedge clk);
    chk("pre_reset_vec", int'({a_v[1], b_v[1], c_v[1]}), 4);
    @(posedge clk);
    #1 rst_v[1] = 1'b0;
    @(negedge clk);
    chk("mid_reset_outputs", int'(dut_out(1)), 0);
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_v[1]) dcnt++;
    end
    chk("mid_reset_no_done", dcnt, 0);
    pulse_start(1);
    wait_done(1, lat, n5);
    chk("post_reset_latency", lat, 16);
    chk("post_reset_err", int'(err_v[1]), 5);

    // Timing for SETTLE = 0 and SETTLE = 3.
    tbl[0] = 8'hF8;
    pulse_start(0);
    wait_done(0, lat, n5);
    chk("s0_latency", lat, 8);
    chk("s0_pass", int'(pass_v[0]), 1);
    tbl[2] = 8'hF8;
    pulse_start(2);
    wait_done(2, lat, n5);
    chk("s3_latency", lat, 32);
    chk("s3_hold_101", n5, 4);

    // Random phase: random datapath faults, start pulses and occasional resets.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        rst_v[k] = ($urandom_range(0, 99) == 0);
        start_v[k] = ($urandom_range(0, 5) == 0);
        if (n_m[k] < 0 && start_v[k]) begin
          case ($urandom_range(0, 3))
            0:       tbl[k] = 8'hF8;
            1:       tbl[k] = 8'h00;
            2:       tbl[k] = 8'hF0;
            default: tbl[k] = 8'($urandom);
          endcase
        end
      end
    end
    @(posedge clk);
    #1;
    rst_v = 3'b000;
    start_v = 3'b000;
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
